// File: rtl/disp_mux_scan_if.sv
// Control-side bundle for disp_mux_scan: source/edit inputs on one side,
// rendered digits and the scanned digit bus on the other.
interface disp_mux_scan_if #(
    parameter int DIGITS  = 4,
    parameter int SOURCES = 3,
    parameter int CODE_W  = 5
);
    localparam int SEL_W = (SOURCES > 1) ? $clog2(SOURCES) : 1;
    localparam int POS_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SOURCES*DIGITS*CODE_W-1:0] src_data;
    logic [SEL_W-1:0]                 src_sel;
    logic                             sel_load;
    logic                             edit_en;
    logic [POS_W-1:0]                 edit_pos;
    logic [CODE_W-1:0]                edit_value;

    logic [DIGITS*CODE_W-1:0]         digit_out;
    logic [DIGITS-1:0]                digit_en;
    logic [CODE_W-1:0]                scan_code;
    logic [DIGITS-1:0]                scan_sel;
    logic                             frame_tick;

    modport master (
        output src_data, src_sel, sel_load, edit_en, edit_pos, edit_value,
        input  digit_out, digit_en, scan_code, scan_sel, frame_tick
    );

    modport slave (
        input  src_data, src_sel, sel_load, edit_en, edit_pos, edit_value,
        output digit_out, digit_en, scan_code, scan_sel, frame_tick
    );
endinterface

// File: rtl/disp_mux_scan.sv
// Display multiplexer: source select, in-place digit edit with blink,
// leading-zero blanking, and a time-multiplexed scanned digit bus.
module disp_mux_scan #(
    parameter int                 DIGITS     = 4,
    parameter int                 SOURCES    = 3,
    parameter int                 CODE_W     = 5,
    parameter logic [CODE_W-1:0]  BLANK_CODE = 5'h10,
    parameter int                 BLINK_DIV  = 10000,
    parameter int                 SCAN_DIV   = 1000,
    parameter int                 LZB        = 1
) (
    input  logic              clk,
    input  logic              rst,
    disp_mux_scan_if.slave    bus
);
    localparam int SEL_W   = (SOURCES > 1) ? $clog2(SOURCES) : 1;
    localparam int POS_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);

    logic [SEL_W-1:0]          act;
    logic [BLINK_W-1:0]        blink_cnt;
    logic                      phase;
    logic                      phase_nxt;
    logic                      blink_wrap;
    logic                      restart;
    logic                      edit_en_q;
    logic [POS_W-1:0]          edit_pos_q;
    logic [SCAN_W-1:0]         scan_cnt;
    logic [POS_W-1:0]          idx;
    logic                      scan_wrap;
    logic [DIGITS*CODE_W-1:0]  render_code;
    logic [DIGITS-1:0]         render_en;

    // The edited digit is rendered with the phase it will have after this
    // edge, so a restart shows it immediately and each half-period is exact.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves a value held and no latch is inferred.
        restart    = 1'b0;
        blink_wrap = 1'b0;
        phase_nxt  = phase;
        restart    = bus.edit_en && (!edit_en_q || (bus.edit_pos != edit_pos_q));
        blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
        if (restart) begin
            phase_nxt = 1'b1;
        end else if (blink_wrap) begin
            phase_nxt = ~phase;
        end
    end

    // Render walks from the top digit down so blanking stops at the first
    // nonzero code; digit 0 is never blanked.
    always_comb begin
        logic [CODE_W-1:0] code;
        logic              edit_active;
        logic              blanking;
        code        = '0;
        render_code = '0;
        render_en   = '1;
        edit_active = bus.edit_en && (int'(bus.edit_pos) < DIGITS);
        blanking    = (LZB != 0);
        for (int d = DIGITS - 1; d >= 0; d--) begin
            code = bus.src_data[(int'(act) * DIGITS + d) * CODE_W +: CODE_W];
            if (edit_active) begin
                if (d > int'(bus.edit_pos)) begin
                    code = BLANK_CODE;
                end else if (d == int'(bus.edit_pos)) begin
                    code         = bus.edit_value;
                    render_en[d] = phase_nxt;
                end
            end else if (blanking && (d != 0) && (code == '0)) begin
                code = BLANK_CODE;
            end else begin
                blanking = 1'b0;
            end
            render_code[d * CODE_W +: CODE_W] = code;
        end
    end

    assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            act            <= '0;
            blink_cnt      <= '0;
            phase          <= 1'b1;
            edit_en_q      <= 1'b0;
            edit_pos_q     <= '0;
            scan_cnt       <= '0;
            idx            <= '0;
            bus.digit_out  <= {DIGITS{BLANK_CODE}};
            bus.digit_en   <= '1;
            bus.scan_code  <= BLANK_CODE;
            bus.scan_sel   <= '0;
            bus.frame_tick <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            if (bus.sel_load && (int'(bus.src_sel) < SOURCES)) begin
                act <= bus.src_sel;
            end
            blink_cnt  <= (restart || blink_wrap) ? '0 : blink_cnt + 1'b1;
            phase      <= phase_nxt;
            edit_en_q  <= bus.edit_en;
            edit_pos_q <= bus.edit_pos;

            bus.digit_out <= render_code;
            bus.digit_en  <= render_en;

            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            if (scan_wrap) begin
                idx <= (idx == POS_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end
            bus.scan_code  <= bus.digit_out[int'(idx) * CODE_W +: CODE_W];
            bus.scan_sel   <= (ONE_HOT0 << idx) & {DIGITS{bus.digit_en[idx]}};
            bus.frame_tick <= scan_wrap && (idx == POS_W'(DIGITS - 1));
        end
    end
endmodule

// File: tb/tb_disp_mux_scan.sv
// Randomized bench for disp_mux_scan against a cycle-count based model of
// the rendering, blink and scan rules.
module tb_disp_mux_scan;
    localparam int D    = 4;
    localparam int S    = 3;
    localparam int W    = 5;
    localparam logic [W-1:0] BLANK = 5'h10;
    localparam int BDIV = 6;
    localparam int SDIV = 3;
    localparam int LZBP = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    disp_mux_scan_if #(.DIGITS(D), .SOURCES(S), .CODE_W(W)) bus ();

    disp_mux_scan #(
        .DIGITS(D), .SOURCES(S), .CODE_W(W), .BLANK_CODE(BLANK),
        .BLINK_DIV(BDIV), .SCAN_DIV(SDIV), .LZB(LZBP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Model state: time since reset drives the scanner, time since the last
    // blink restart drives the blink phase.
    int           m_act, m_prev_pos, m_t, m_n;
    logic         m_prev_en;
    logic [W-1:0] e_dig [D];
    logic         e_en  [D];
    logic [W-1:0] e_scode;
    logic [D-1:0] e_ssel;
    logic         e_ft;

    task automatic model_edge();
        int   cur, pos;
        logic vis;
        if (rst) begin
            m_act = 0; m_prev_en = 1'b0; m_prev_pos = 0; m_t = 0; m_n = 0;
            for (int d = 0; d < D; d++) begin
                e_dig[d] = BLANK;
                e_en[d]  = 1'b1;
            end
            e_scode = BLANK; e_ssel = '0; e_ft = 1'b0;
        end else begin
            cur = (m_n / SDIV) % D;
            e_scode = e_dig[cur];
            e_ssel = '0;
            e_ssel[cur] = e_en[cur];
            m_n++;
            e_ft = (m_n % (D * SDIV)) == 0;

            pos = int'(bus.edit_pos);
            if (bus.edit_en && (!m_prev_en || pos != m_prev_pos)) m_t = 0;
            else m_t++;
            vis = ((m_t / BDIV) % 2) == 0;

            for (int d = 0; d < D; d++) begin
                e_dig[d] = bus.src_data[(m_act * D + d) * W +: W];
                e_en[d]  = 1'b1;
                if (bus.edit_en) begin
                    if (d > pos) e_dig[d] = BLANK;
                    else if (d == pos) begin
                        e_dig[d] = bus.edit_value;
                        e_en[d]  = vis;
                    end
                end
            end
            if (!bus.edit_en && LZBP == 1) begin
                for (int d = D - 1; d > 0; d--) begin
                    if (e_dig[d] != 0) break;
                    e_dig[d] = BLANK;
                end
            end
            m_prev_en  = bus.edit_en;
            m_prev_pos = pos;
            if (bus.sel_load && int'(bus.src_sel) < S) m_act = int'(bus.src_sel);
        end
    endtask

    task automatic step();
        logic [D*W-1:0] exp_dig;
        logic [D-1:0]   exp_en;
        model_edge();
        @(posedge clk);
        #1;
        for (int d = 0; d < D; d++) begin
            exp_dig[d*W +: W] = e_dig[d];
            exp_en[d]         = e_en[d];
        end
        check("digit_out",  64'(bus.digit_out),  64'(exp_dig));
        check("digit_en",   64'(bus.digit_en),   64'(exp_en));
        check("scan_code",  64'(bus.scan_code),  64'(e_scode));
        check("scan_sel",   64'(bus.scan_sel),   64'(e_ssel));
        check("frame_tick", 64'(bus.frame_tick), 64'(e_ft));
    endtask

    task automatic set_src(input int s, input logic [W-1:0] c3, input logic [W-1:0] c2,
                           input logic [W-1:0] c1, input logic [W-1:0] c0);
        bus.src_data[(s*D+3)*W +: W] = c3;
        bus.src_data[(s*D+2)*W +: W] = c2;
        bus.src_data[(s*D+1)*W +: W] = c1;
        bus.src_data[(s*D+0)*W +: W] = c0;
    endtask

    // Zero-heavy codes so leading-zero blanking is exercised often.
    task automatic randomize_src();
        int r;
        for (int i = 0; i < S * D; i++) begin
            r = $urandom_range(0, 3);
            if (r < 2)       bus.src_data[i*W +: W] = '0;
            else if (r == 2) bus.src_data[i*W +: W] = W'($urandom_range(0, 9));
            else             bus.src_data[i*W +: W] = W'($urandom_range(0, 31));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst            = 1'b1;
        bus.src_data   = '0;
        bus.src_sel    = '0;
        bus.sel_load   = 1'b0;
        bus.edit_en    = 1'b0;
        bus.edit_pos   = '0;
        bus.edit_value = '0;
        run(2);
        check("rst_digit_out", 64'(bus.digit_out), 64'({BLANK, BLANK, BLANK, BLANK}));
        check("rst_scan_sel",  64'(bus.scan_sel),  64'd0);
        rst = 1'b0;

        // Source select with leading-zero blanking, two-cycle latency.
        set_src(2, 5'd0, 5'd0, 5'd4, 5'd7);
        bus.src_sel  = 2'd2;
        bus.sel_load = 1'b1;
        step();
        bus.sel_load = 1'b0;
        step();
        check("sel_lzb", 64'(bus.digit_out), 64'({BLANK, BLANK, 5'd4, 5'd7}));

        // Edit at position 1, blink over several half-periods, then move.
        set_src(2, 5'd0, 5'd0, 5'd4, 5'd3);
        bus.edit_en    = 1'b1;
        bus.edit_pos   = 2'd1;
        bus.edit_value = 5'd9;
        step();
        check("edit_render", 64'(bus.digit_out), 64'({BLANK, BLANK, 5'd9, 5'd3}));
        run(4 * BDIV + 2);
        bus.edit_pos = 2'd2;
        step();
        check("edit_move_vis", 64'(bus.digit_en[2]), 64'd1);
        run(3 * BDIV);

        // Out-of-range source select is ignored.
        bus.src_sel  = 2'd3;
        bus.sel_load = 1'b1;
        step();
        bus.sel_load = 1'b0;
        bus.edit_en  = 1'b0;
        run(3);

        // All-zero source and a glyph in the top digit.
        set_src(2, 5'd0, 5'd0, 5'd0, 5'd0);
        run(2);
        check("lzb_zero", 64'(bus.digit_out), 64'({BLANK, BLANK, BLANK, 5'd0}));
        set_src(2, 5'h11, 5'd0, 5'd0, 5'd2);
        run(2);
        check("lzb_glyph", 64'(bus.digit_out), 64'({5'h11, 5'd0, 5'd0, 5'd2}));
        run(2 * D * SDIV);

        // Random traffic with occasional mid-operation resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) randomize_src();
            bus.sel_load = ($urandom_range(0, 5) == 0);
            bus.src_sel  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) bus.edit_en = ~bus.edit_en;
            if ($urandom_range(0, 19) == 0) bus.edit_pos = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)  bus.edit_value = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;

        // Reset in the middle of a frame and a blink half-period.
        bus.edit_en  = 1'b1;
        bus.edit_pos = 2'd0;
        run(D * SDIV + 4);
        rst = 1'b1;
        step();
        check("mid_rst_digit_out", 64'(bus.digit_out), 64'({BLANK, BLANK, BLANK, BLANK}));
        check("mid_rst_digit_en",  64'(bus.digit_en),  64'(4'b1111));
        check("mid_rst_scan_code", 64'(bus.scan_code), 64'(BLANK));
        rst = 1'b0;
        step();
        check("post_rst_idx0", 64'(bus.scan_sel), 64'(4'b0001));
        run(2 * D * SDIV);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
